// File: rtl/mem_ctrl.sv
// mem_ctrl: memory-side responder for the instruction fetch port and the
// load/store buffer. Arbitrates between the two requesters (LSB first),
// serializes each 1/2/4-byte access onto the byte-wide RAM/IO bus and
// returns a one-cycle valid pulse with the assembled little-endian word.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rdy                 global enable; low freezes every register
//   io_buffer_full      IO write buffer full; stalls stores to the IO region
//   if_addr_enable      fetch request (held until if_valid)
//   if_addr             word-aligned fetch address
//   if_valid, if_data   fetch completion pulse and instruction word
//   ls_enable, ls_wr    LSB request, 1 = store / 0 = load
//   ls_size             0 = byte, 1 = half, 2/3 = word
//   ls_addr, ls_wdata   byte address and store data
//   ls_valid, ls_rdata  LSB completion pulse and zero-extended load data
//   mem_din             byte returned by RAM/IO one cycle after its address
//   mem_dout, mem_a     write byte and byte address toward RAM/IO
//   mem_wr              1 = write cycle
//
// The read path assumes the RAM/IO side honours the same rdy freeze, so the
// byte on mem_din is still the one for the previous address after a stall.
module mem_ctrl #(
  parameter logic [1:0] IO_ADDR_HI = 2'b11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        io_buffer_full,
  input  logic        if_addr_enable,
  input  logic [31:0] if_addr,
  output logic        if_valid,
  output logic [31:0] if_data,
  input  logic        ls_enable,
  input  logic        ls_wr,
  input  logic [1:0]  ls_size,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_valid,
  output logic [31:0] ls_rdata,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t      state, state_nxt;
  logic [2:0]  cnt, cnt_nxt;
  logic [2:0]  len, len_nxt;
  logic [31:0] base, base_nxt;
  logic [31:0] wdata, wdata_nxt;
  logic        from_ls, from_ls_nxt;
  logic [31:0] rbuf, rbuf_nxt;
  logic        mem_wr_q, mem_wr_nxt;
  logic [31:0] mem_a_nxt;
  logic [7:0]  mem_dout_nxt;
  logic        if_valid_nxt, ls_valid_nxt;
  logic [31:0] if_data_nxt, ls_rdata_nxt;

  logic [2:0]  widx;
  logic [2:0]  cnt_inc;
  logic [4:0]  rshift;
  logic        io_stall;

  // A frozen cycle must never write, even though the write strobe register
  // still holds the pending byte that is replayed once rdy returns.
  assign mem_wr = mem_wr_q & rdy;

  // In READ, cnt is the number of READ cycles already spent: address cnt is
  // on the bus and the byte for address cnt-1 is arriving on mem_din.
  // In WRITE, cnt is the index of the byte currently presented (or pending
  // behind an IO stall); widx is the byte to present next cycle.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    len_nxt      = len;
    base_nxt     = base;
    wdata_nxt    = wdata;
    from_ls_nxt  = from_ls;
    rbuf_nxt     = rbuf;
    mem_wr_nxt   = 1'b0;
    mem_a_nxt    = mem_a;
    mem_dout_nxt = mem_dout;
    if_valid_nxt = 1'b0;
    ls_valid_nxt = 1'b0;
    if_data_nxt  = if_data;
    ls_rdata_nxt = ls_rdata;
    widx         = cnt + {2'b00, mem_wr_q};
    cnt_inc      = cnt + 3'd1;
    rshift       = {(cnt[1:0] - 2'd1), 3'b000};
    io_stall     = (base[17:16] == IO_ADDR_HI) && io_buffer_full;

    case (state)
      IDLE: begin
        cnt_nxt   = 3'd0;
        rbuf_nxt  = 32'd0;
        mem_a_nxt = 32'd0;
        if (ls_enable) begin
          base_nxt    = ls_addr;
          wdata_nxt   = ls_wdata;
          from_ls_nxt = 1'b1;
          len_nxt     = (ls_size == 2'd0) ? 3'd1 : (ls_size == 2'd1) ? 3'd2 : 3'd4;
          mem_a_nxt   = ls_addr;
          if (ls_wr) begin
            state_nxt    = WRITE;
            mem_dout_nxt = ls_wdata[7:0];
            mem_wr_nxt   = !((ls_addr[17:16] == IO_ADDR_HI) && io_buffer_full);
          end else begin
            state_nxt = READ;
          end
        end else if (if_addr_enable) begin
          base_nxt    = if_addr;
          from_ls_nxt = 1'b0;
          len_nxt     = 3'd4;
          mem_a_nxt   = if_addr;
          state_nxt   = READ;
        end
      end

      READ: begin
        if (cnt != 3'd0) begin
          rbuf_nxt = rbuf | ({24'd0, mem_din} << rshift);
        end
        if (cnt == len) begin
          state_nxt = DONE;
          if (from_ls) begin
            ls_valid_nxt = 1'b1;
            ls_rdata_nxt = rbuf_nxt;
          end else begin
            if_valid_nxt = 1'b1;
            if_data_nxt  = rbuf_nxt;
          end
        end else begin
          cnt_nxt = cnt_inc;
          if (cnt_inc < len) begin
            mem_a_nxt = base + {29'd0, cnt_inc};
          end
        end
      end

      WRITE: begin
        if (widx == len) begin
          state_nxt    = DONE;
          ls_valid_nxt = 1'b1;
        end else begin
          cnt_nxt = widx;
          if (!io_stall) begin
            mem_wr_nxt   = 1'b1;
            mem_a_nxt    = base + {29'd0, widx};
            mem_dout_nxt = wdata[{widx[1:0], 3'b000} +: 8];
          end
        end
      end

      DONE: begin
        // Requesters still show enable this cycle; ignoring them here is
        // what prevents the same request from being served twice.
        state_nxt = IDLE;
        mem_a_nxt = 32'd0;
      end

      default: state_nxt = IDLE;
    endcase
  end

  // Every register freezes while rdy is low; reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 3'd0;
      len      <= 3'd0;
      base     <= 32'd0;
      wdata    <= 32'd0;
      from_ls  <= 1'b0;
      rbuf     <= 32'd0;
      mem_wr_q <= 1'b0;
      mem_a    <= 32'd0;
      mem_dout <= 8'd0;
      if_valid <= 1'b0;
      ls_valid <= 1'b0;
      if_data  <= 32'd0;
      ls_rdata <= 32'd0;
    end else if (rdy) begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      len      <= len_nxt;
      base     <= base_nxt;
      wdata    <= wdata_nxt;
      from_ls  <= from_ls_nxt;
      rbuf     <= rbuf_nxt;
      mem_wr_q <= mem_wr_nxt;
      mem_a    <= mem_a_nxt;
      mem_dout <= mem_dout_nxt;
      if_valid <= if_valid_nxt;
      ls_valid <= ls_valid_nxt;
      if_data  <= if_data_nxt;
      ls_rdata <= ls_rdata_nxt;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: self-checking bench for mem_ctrl. A byte-wide RAM model sits
// on the memory bus; a separate reference memory tracks what every byte
// should hold, so load results and bus traffic are predicted from the
// access rules alone (per-cycle address/data, latency, valid pulses).
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy, io_buffer_full;
  logic        if_addr_enable, ls_enable, ls_wr;
  logic [31:0] if_addr, ls_addr, ls_wdata;
  logic [1:0]  ls_size;
  logic [7:0]  mem_din = 8'd0;
  logic        if_valid, ls_valid, mem_wr;
  logic [31:0] if_data, ls_rdata, mem_a;
  logic [7:0]  mem_dout;

  int checks = 0;
  int errors = 0;

  logic [7:0] ram_mem [bit [31:0]];
  logic [7:0] ref_mem [bit [31:0]];

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .io_buffer_full(io_buffer_full),
    .if_addr_enable(if_addr_enable), .if_addr(if_addr),
    .if_valid(if_valid), .if_data(if_data),
    .ls_enable(ls_enable), .ls_wr(ls_wr), .ls_size(ls_size),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_valid(ls_valid), .ls_rdata(ls_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] fill_byte(bit [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ram_read(bit [31:0] a);
    return ram_mem.exists(a) ? ram_mem[a] : fill_byte(a);
  endfunction

  function automatic logic [7:0] ref_read(bit [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : fill_byte(a);
  endfunction

  // RAM model: one-cycle read latency, frozen together with the system.
  always @(posedge clk) begin
    if (rdy) begin
      mem_din <= ram_read(mem_a);
      if (mem_wr) ram_mem[mem_a] = mem_dout;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // One request from one source, started in the current (idle) cycle.
  // low_at: first of two rdy-low cycles (0 = none); full_cycles: cycles of
  // io_buffer_full asserted from the request cycle on.
  task automatic applyStimulus(input bit is_ls, input bit wr, input logic [1:0] size,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input int low_at, input int full_cycles);
    int n, n_done, c, lows, e, budget;
    bit io_store, done, own_v, other_v;
    logic [31:0] exp_data, exp_byte;
    n = !is_ls ? 4 : (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    n_done = wr ? n + 1 : n + 2;
    io_store = is_ls && wr && (addr[17:16] == 2'b11) && (full_cycles > 0);
    exp_data = 32'd0;
    for (int k = 0; k < n; k++) begin
      if (wr) ref_mem[addr + k] = wdata[8*k +: 8];
      else exp_data = exp_data | ({24'd0, ref_read(addr + k)} << (8 * k));
    end
    if (is_ls) begin
      ls_enable = 1'b1; ls_wr = wr; ls_size = size; ls_addr = addr; ls_wdata = wdata;
    end else begin
      if_addr_enable = 1'b1; if_addr = addr;
    end
    io_buffer_full = (full_cycles > 0);
    budget = n_done + full_cycles + 12;
    c = 0; lows = 0; done = 1'b0;
    while (!done && c < budget) begin
      @(posedge clk);
      #1;
      c++;
      rdy = !(low_at > 0 && c >= low_at && c < low_at + 2);
      io_buffer_full = (c < full_cycles);
      @(negedge clk);
      e = c - lows - (io_store ? full_cycles : 0);
      own_v   = is_ls ? ls_valid : if_valid;
      other_v = is_ls ? if_valid : ls_valid;
      checkOutput("other_valid", other_v, 1'b0);
      if (!rdy || (io_store && c <= full_cycles)) begin
        checkOutput("stall_mem_wr", mem_wr, 1'b0);
      end else begin
        checkOutput("valid_timing", own_v, (e == n_done));
        if (!wr) checkOutput("read_mem_wr", mem_wr, 1'b0);
        if (e >= 1 && e <= n) begin
          checkOutput("bus_addr", mem_a, addr + (e - 1));
          if (wr) begin
            exp_byte = (wdata >> (8 * (e - 1))) & 32'hFF;
            checkOutput("write_strobe", mem_wr, 1'b1);
            checkOutput("write_byte", {24'd0, mem_dout}, exp_byte);
          end
        end
      end
      if (!rdy) lows++;
      if (own_v && rdy) begin
        done = 1'b1;
        if (!wr) checkOutput(is_ls ? "load_data" : "fetch_data",
                             is_ls ? ls_rdata : if_data, exp_data);
      end
    end
    checkOutput("valid_seen", done, 1'b1);
    @(posedge clk);
    #1;
    ls_enable = 1'b0; if_addr_enable = 1'b0; rdy = 1'b1; io_buffer_full = 1'b0;
    @(negedge clk);
    checkOutput("valid_once", is_ls ? ls_valid : if_valid, 1'b0);
  endtask

  initial begin
    int ls_cyc, if_cyc, ls_cnt, if_cnt;
    logic [31:0] exp_ls, rd_addr;
    bit r_ls, r_wr;
    logic [1:0] r_size;

    rst = 1'b1; rdy = 1'b1; io_buffer_full = 1'b0;
    if_addr_enable = 1'b0; ls_enable = 1'b0; ls_wr = 1'b0;
    if_addr = 32'd0; ls_addr = 32'd0; ls_wdata = 32'd0; ls_size = 2'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_mem_wr", mem_wr, 1'b0);
    checkOutput("rst_mem_a", mem_a, 32'd0);
    checkOutput("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
    checkOutput("rst_if_valid", if_valid, 1'b0);
    checkOutput("rst_ls_valid", ls_valid, 1'b0);
    checkOutput("rst_if_data", if_data, 32'd0);
    checkOutput("rst_ls_rdata", ls_rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Instruction at 0x100: 13 05 00 00 -> 0x00000513
    ram_mem[32'h100] = 8'h13; ram_mem[32'h101] = 8'h05;
    ram_mem[32'h102] = 8'h00; ram_mem[32'h103] = 8'h00;
    ref_mem[32'h100] = 8'h13; ref_mem[32'h101] = 8'h05;
    ref_mem[32'h102] = 8'h00; ref_mem[32'h103] = 8'h00;
    ram_mem[32'h2001] = 8'hF0; ref_mem[32'h2001] = 8'hF0;

    applyStimulus(1'b0, 1'b0, 2'd2, 32'h100, 32'd0, 0, 0);
    checkOutput("fetch_word", if_data, 32'h0000_0513);
    applyStimulus(1'b1, 1'b0, 2'd0, 32'h2001, 32'd0, 0, 0);
    checkOutput("load_byte", ls_rdata, 32'h0000_00F0);
    applyStimulus(1'b1, 1'b1, 2'd2, 32'h40, 32'hDEADBEEF, 0, 0);
    applyStimulus(1'b1, 1'b0, 2'd2, 32'h40, 32'd0, 0, 0);
    checkOutput("load_back", ls_rdata, 32'hDEADBEEF);
    applyStimulus(1'b1, 1'b1, 2'd0, 32'h30000, 32'h0000_00A5, 0, 3);
    applyStimulus(1'b0, 1'b0, 2'd2, 32'h100, 32'd0, 3, 0);
    applyStimulus(1'b1, 1'b0, 2'd3, 32'hFFFF_FFFE, 32'd0, 0, 0);

    // Simultaneous fetch and halfword load: load first, fetch after.
    exp_ls = {16'd0, ref_read(32'h41), ref_read(32'h40)};
    ls_enable = 1'b1; ls_wr = 1'b0; ls_size = 2'd1; ls_addr = 32'h40;
    if_addr_enable = 1'b1; if_addr = 32'h100;
    ls_cyc = 0; if_cyc = 0; ls_cnt = 0; if_cnt = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (ls_cnt > 0) ls_enable = 1'b0;
      if (if_cnt > 0) if_addr_enable = 1'b0;
      @(negedge clk);
      if (ls_valid) begin
        ls_cnt++; ls_cyc = c;
        checkOutput("sim_load_data", ls_rdata, exp_ls);
      end
      if (if_valid) begin
        if_cnt++; if_cyc = c;
        checkOutput("sim_fetch_data", if_data, 32'h0000_0513);
      end
    end
    checkOutput("sim_ls_count", ls_cnt, 1);
    checkOutput("sim_if_count", if_cnt, 1);
    checkOutput("sim_ls_cycle", ls_cyc, 4);
    checkOutput("sim_if_cycle", if_cyc, 11);

    // Reset after two bytes of a word store: aborts with no valid.
    ls_enable = 1'b1; ls_wr = 1'b1; ls_size = 2'd2; ls_addr = 32'h50;
    ls_wdata = 32'h1122_3344;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("pre_rst_wr", mem_wr, 1'b1);
    end
    rst = 1'b1; ls_enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_mem_wr", mem_wr, 1'b0);
    checkOutput("abort_mem_a", mem_a, 32'd0);
    checkOutput("abort_valid", ls_valid, 1'b0);
    ref_mem[32'h50] = 8'h44; ref_mem[32'h51] = 8'h33;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("abort_quiet_wr", mem_wr, 1'b0);
      checkOutput("abort_quiet_v", ls_valid, 1'b0);
    end

    // Randomized traffic over a small address pool so loads see stores.
    for (int i = 0; i < 40; i++) begin
      r_ls = ($urandom_range(0, 2) != 0);
      r_wr = r_ls && ($urandom_range(0, 1) == 1);
      r_size = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: rd_addr = 32'h40 + 32'($urandom_range(0, 18));
        1: rd_addr = 32'h30000 + 32'($urandom_range(0, 15));
        2: rd_addr = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
        default: rd_addr = 32'h2000 + 32'($urandom_range(0, 15));
      endcase
      if (!r_ls) rd_addr = rd_addr & 32'hFFFF_FFFC;
      applyStimulus(r_ls, r_wr, r_size, rd_addr, $urandom,
                    ($urandom_range(0, 3) == 0) ? 1 : 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
